// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory stage.
//   mem_state_t : load-wait FSM state
//   br_type_t   : branch-type encoding; BrNone means "not a branch"
//   mem_wb_t    : MEM/WB pipeline register contents
package mem_stage_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

    typedef enum logic [2:0] {
        BrNone = 3'd0,
        BrBeq  = 3'd1,
        BrBne  = 3'd2,
        BrBlez = 3'd3,
        BrBgtz = 3'd4,
        BrBltz = 3'd5,
        BrBgez = 3'd6,
        BrJump = 3'd7
    } br_type_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  rw;
        logic [31:0] data;
        logic [29:0] pcp1;
    } mem_wb_t;

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load align/extend for the memory stage (purely combinational).
//   word_i        : raw 32-bit word from the data-memory bridge
//   off_i         : byte offset within the word (little-endian lanes)
//   is_byte_i     : byte load (takes priority over half)
//   is_half_i     : halfword load
//   is_unsigned_i : zero-extend instead of sign-extend
//   ext_o         : aligned, extended load result; word loads pass through
module load_ext (
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic        is_byte_i,
    input  logic        is_half_i,
    input  logic        is_unsigned_i,
    output logic [31:0] ext_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word_i[7:0];
        unique case (off_i)
            2'd0: byte_lane = word_i[7:0];
            2'd1: byte_lane = word_i[15:8];
            2'd2: byte_lane = word_i[23:16];
            2'd3: byte_lane = word_i[31:24];
            default: byte_lane = word_i[7:0];
        endcase
    end

    // Halfword lane selected by the upper offset bit only.
    assign half_lane = off_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        ext_o = word_i;
        if (is_byte_i) begin
            ext_o = {{24{byte_lane[7] & ~is_unsigned_i}}, byte_lane};
        end else if (is_half_i) begin
            ext_o = {{16{half_lane[15] & ~is_unsigned_i}}, half_lane};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: aligns/extends loads, resolves branches deferred to MEM, drives
// the MEM bypass bus and owns the MEM/WB register. Stalls while a load waits
// for a slow bridge response, with a bus-error timeout after WAIT_LIMIT cycles.
//   clk, rst            : clock, synchronous active-high reset
//   mem_flush           : squash the instruction in MEM
//   ex_*                : EX/MEM register contents (held stable while stalled)
//   dm_rdata/dm_rvalid  : bridge read data and its valid strobe
//   mem_stall           : hold IF..EX/MEM this cycle
//   mem_busErr          : one-cycle pulse after a load timeout
//   correctAtMEM/PC     : misprediction redirect and its target
//   MEM_*               : bypass bus back to EX
//   wb_*                : MEM/WB register outputs
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_flush,
    input  logic        ex_regWrite,
    input  logic        ex_memToReg,
    input  logic        ex_isDMByte,
    input  logic        ex_isDMHalf,
    input  logic        ex_dmUnsigned,
    input  logic [29:0] ex_pcp1,
    input  logic [4:0]  ex_rw,
    input  logic [31:0] ex_exout,
    input  logic [2:0]  ex_branchType,
    input  logic        ex_commitAtMEM,
    input  logic        ex_predictAvail,
    input  logic        ex_EXBranchAvail,
    input  logic [29:0] ex_BPC,
    input  logic [29:0] ex_NOJPC,
    input  logic [31:0] dm_rdata,
    input  logic        dm_rvalid,
    output logic        mem_stall,
    output logic        mem_busErr,
    output logic        correctAtMEM,
    output logic [29:0] correctPCAtMEM,
    output logic        MEM_regWrite,
    output logic        MEM_memToReg,
    output logic [4:0]  MEM_rw,
    output logic [31:0] MEM_EXT_MEMout,
    output logic        wb_regWrite,
    output logic [4:0]  wb_rw,
    output logic [31:0] wb_data,
    output logic [29:0] wb_pcp1
);

    localparam int unsigned CntW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    // Last WAIT cycle index; reaching it without dm_rvalid is the timeout.
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_LIMIT - 1);

    mem_state_t      state_q;
    logic [CntW-1:0] cnt_q;
    logic            br_done_q;
    logic            bus_err_q;
    mem_wb_t         wb_q;

    logic [31:0] ext;
    logic [31:0] res;
    logic        stall;
    logic        timeout;

    load_ext u_load_ext (
        .word_i        (dm_rdata),
        .off_i         (ex_exout[1:0]),
        .is_byte_i     (ex_isDMByte),
        .is_half_i     (ex_isDMHalf),
        .is_unsigned_i (ex_dmUnsigned),
        .ext_o         (ext)
    );

    assign res = ex_memToReg ? ext : ex_exout;

    // Stall/timeout decode. A squashed instruction never stalls, so upstream
    // can advance in the same cycle the flush is applied.
    always_comb begin
        stall   = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            IDLE: stall = ex_memToReg && !dm_rvalid;
            WAIT: begin
                timeout = !dm_rvalid && (cnt_q == CntLast);
                stall   = !dm_rvalid && !timeout;
            end
            default: ;
        endcase
        if (rst || mem_flush) begin
            stall   = 1'b0;
            timeout = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || mem_flush) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            br_done_q <= 1'b0;
            bus_err_q <= 1'b0;
            wb_q      <= '0;
        end else begin
            bus_err_q <= timeout;
            if (stall) begin
                wb_q    <= '0;
                state_q <= WAIT;
                cnt_q   <= (state_q == IDLE) ? '0 : cnt_q + CntW'(1);
                // Remember the redirect so a held branch pulses only once.
                if (correctAtMEM) begin
                    br_done_q <= 1'b1;
                end
            end else begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                br_done_q <= 1'b0;
                if (timeout) begin
                    wb_q <= '0;
                end else begin
                    wb_q <= '{reg_write: ex_regWrite, rw: ex_rw, data: res, pcp1: ex_pcp1};
                end
            end
        end
    end

    assign mem_stall  = stall;
    assign mem_busErr = bus_err_q;

    assign correctAtMEM   = ex_commitAtMEM && (ex_branchType != BrNone) &&
                            (ex_predictAvail != ex_EXBranchAvail) && !br_done_q;
    assign correctPCAtMEM = ex_EXBranchAvail ? ex_BPC : ex_NOJPC;

    assign MEM_regWrite   = ex_regWrite && !stall;
    assign MEM_memToReg   = ex_memToReg;
    assign MEM_rw         = ex_rw;
    assign MEM_EXT_MEMout = res;

    assign wb_regWrite = wb_q.reg_write;
    assign wb_rw       = wb_q.rw;
    assign wb_data     = wb_q.data;
    assign wb_pcp1     = wb_q.pcp1;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int unsigned WaitLimit = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_flush;
    logic        ex_regWrite, ex_memToReg, ex_isDMByte, ex_isDMHalf, ex_dmUnsigned;
    logic [29:0] ex_pcp1;
    logic [4:0]  ex_rw;
    logic [31:0] ex_exout;
    logic [2:0]  ex_branchType;
    logic        ex_commitAtMEM, ex_predictAvail, ex_EXBranchAvail;
    logic [29:0] ex_BPC, ex_NOJPC;
    logic [31:0] dm_rdata;
    logic        dm_rvalid;
    logic        mem_stall, mem_busErr, correctAtMEM;
    logic [29:0] correctPCAtMEM;
    logic        MEM_regWrite, MEM_memToReg;
    logic [4:0]  MEM_rw;
    logic [31:0] MEM_EXT_MEMout;
    logic        wb_regWrite;
    logic [4:0]  wb_rw;
    logic [31:0] wb_data;
    logic [29:0] wb_pcp1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.WAIT_LIMIT(WaitLimit)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_flush        (mem_flush),
        .ex_regWrite      (ex_regWrite),
        .ex_memToReg      (ex_memToReg),
        .ex_isDMByte      (ex_isDMByte),
        .ex_isDMHalf      (ex_isDMHalf),
        .ex_dmUnsigned    (ex_dmUnsigned),
        .ex_pcp1          (ex_pcp1),
        .ex_rw            (ex_rw),
        .ex_exout         (ex_exout),
        .ex_branchType    (ex_branchType),
        .ex_commitAtMEM   (ex_commitAtMEM),
        .ex_predictAvail  (ex_predictAvail),
        .ex_EXBranchAvail (ex_EXBranchAvail),
        .ex_BPC           (ex_BPC),
        .ex_NOJPC         (ex_NOJPC),
        .dm_rdata         (dm_rdata),
        .dm_rvalid        (dm_rvalid),
        .mem_stall        (mem_stall),
        .mem_busErr       (mem_busErr),
        .correctAtMEM     (correctAtMEM),
        .correctPCAtMEM   (correctPCAtMEM),
        .MEM_regWrite     (MEM_regWrite),
        .MEM_memToReg     (MEM_memToReg),
        .MEM_rw           (MEM_rw),
        .MEM_EXT_MEMout   (MEM_EXT_MEMout),
        .wb_regWrite      (wb_regWrite),
        .wb_rw            (wb_rw),
        .wb_data          (wb_data),
        .wb_pcp1          (wb_pcp1)
    );

    // Reference load result: shift the addressed lane down, mask, sign-fill.
    function automatic logic [31:0] ref_ext(input logic [31:0] word, input logic [31:0] addr,
                                            input logic b, input logic h, input logic u);
        logic [31:0] v;
        int sh;
        if (b) begin
            sh = 8 * int'(addr[1:0]);
            v = (word >> sh) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (h) begin
            sh = addr[1] ? 16 : 0;
            v = (word >> sh) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_regWrite = 0; ex_memToReg = 0; ex_isDMByte = 0; ex_isDMHalf = 0; ex_dmUnsigned = 0;
        ex_pcp1 = '0; ex_rw = '0; ex_exout = '0; ex_branchType = '0;
        ex_commitAtMEM = 0; ex_predictAvail = 0; ex_EXBranchAvail = 0;
        ex_BPC = '0; ex_NOJPC = '0; dm_rdata = '0; dm_rvalid = 0;
    endtask

    task automatic test_reset();
        rst = 1; mem_flush = 0;
        clear_inputs();
        tick(); tick();
        checks++;
        if ({wb_regWrite, wb_rw, wb_data, wb_pcp1} !== '0) begin
            failures++;
            $display("FAIL reset_wb got=%h exp=0", {wb_regWrite, wb_rw, wb_data, wb_pcp1});
        end
        checks++;
        if ({mem_busErr, mem_stall, correctAtMEM} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000", {mem_busErr, mem_stall, correctAtMEM});
        end
        rst = 0;
        tick();
    endtask

    task automatic test_alu();
        logic [31:0] e_data;
        logic [4:0]  e_rw;
        logic [29:0] e_pc;
        logic        e_we;
        for (int i = 0; i < 9; i++) begin
            clear_inputs();
            if (i == 0) begin
                e_data = 32'h1234_5678; e_rw = 5'd5; e_we = 1'b1; e_pc = 30'h0000_0400;
            end else begin
                e_data = $urandom; e_rw = 5'($urandom); e_we = 1'($urandom); e_pc = 30'($urandom);
            end
            ex_exout = e_data; ex_rw = e_rw; ex_regWrite = e_we; ex_pcp1 = e_pc;
            #1;
            checks++;
            if ({MEM_regWrite, MEM_rw, MEM_EXT_MEMout, mem_stall} !== {e_we, e_rw, e_data, 1'b0}) begin
                failures++;
                $display("FAIL alu_bypass[%0d] got=%h exp=%h", i,
                         {MEM_regWrite, MEM_rw, MEM_EXT_MEMout, mem_stall}, {e_we, e_rw, e_data, 1'b0});
            end
            tick();
            checks++;
            if ({wb_regWrite, wb_rw, wb_data, wb_pcp1} !== {e_we, e_rw, e_data, e_pc}) begin
                failures++;
                $display("FAIL alu_wb[%0d] got=%h exp=%h", i,
                         {wb_regWrite, wb_rw, wb_data, wb_pcp1}, {e_we, e_rw, e_data, e_pc});
            end
        end
    endtask

    task automatic test_load_hit();
        logic [31:0] exp;
        int unsigned sel;
        for (int i = 0; i < 14; i++) begin
            clear_inputs();
            ex_memToReg = 1; ex_regWrite = 1; ex_rw = 5'($urandom); dm_rvalid = 1;
            if (i == 0) begin
                dm_rdata = 32'h80FF_FFFF; ex_exout = 32'h0000_1003; ex_isDMByte = 1;
                exp = 32'hFFFF_FF80;
            end else if (i == 1) begin
                dm_rdata = 32'h80FF_FFFF; ex_exout = 32'h0000_1002; ex_isDMHalf = 1;
                ex_dmUnsigned = 1;
                exp = 32'h0000_80FF;
            end else begin
                sel = $urandom_range(0, 2);
                dm_rdata = $urandom; ex_exout = $urandom;
                ex_isDMByte = (sel == 0); ex_isDMHalf = (sel == 1); ex_dmUnsigned = 1'($urandom);
                exp = ref_ext(dm_rdata, ex_exout, ex_isDMByte, ex_isDMHalf, ex_dmUnsigned);
            end
            #1;
            checks++;
            if ({mem_stall, MEM_EXT_MEMout} !== {1'b0, exp}) begin
                failures++;
                $display("FAIL load_hit_bypass[%0d] got=%h exp=%h", i,
                         {mem_stall, MEM_EXT_MEMout}, {1'b0, exp});
            end
            tick();
            checks++;
            if ({wb_regWrite, wb_data} !== {1'b1, exp}) begin
                failures++;
                $display("FAIL load_hit_wb[%0d] got=%h exp=%h", i, {wb_regWrite, wb_data}, {1'b1, exp});
            end
        end
    endtask

    // Loads whose dm_rvalid arrives k cycles late: k stall cycles, k bubbles,
    // then the data; k == WaitLimit is the last cycle that still completes.
    task automatic test_back_to_back();
        logic [31:0] exp, word;
        int k, stalls, bad_bubbles, bad_bypass;
        logic err_seen;
        int unsigned sel;
        for (int n = 0; n < 12; n++) begin
            k = (n == 0) ? 3 : (n == 1) ? int'(WaitLimit) : int'($urandom_range(0, 5));
            clear_inputs();
            sel = $urandom_range(0, 2);
            ex_memToReg = 1; ex_regWrite = 1; ex_rw = 5'($urandom); ex_pcp1 = 30'($urandom);
            ex_exout = $urandom; ex_isDMByte = (sel == 0); ex_isDMHalf = (sel == 1);
            ex_dmUnsigned = 1'($urandom);
            word = $urandom;
            exp = ref_ext(word, ex_exout, ex_isDMByte, ex_isDMHalf, ex_dmUnsigned);
            stalls = 0; bad_bubbles = 0; bad_bypass = 0; err_seen = 0;
            for (int c = 0; c < k; c++) begin
                dm_rdata = $urandom;
                #1;
                if (mem_stall) stalls++;
                if (MEM_regWrite) bad_bypass++;
                err_seen |= mem_busErr;
                tick();
                if (wb_regWrite !== 1'b0) bad_bubbles++;
            end
            dm_rdata = word; dm_rvalid = 1;
            #1;
            checks++;
            if ({stalls, bad_bubbles, bad_bypass, mem_stall} !== {k, 32'd0, 32'd0, 1'b0}) begin
                failures++;
                $display("FAIL late_stall[k=%0d] stalls=%0d bubbles_written=%0d bypass_we=%0d stall_now=%b exp_stalls=%0d",
                         k, stalls, bad_bubbles, bad_bypass, mem_stall, k);
            end
            tick();
            err_seen |= mem_busErr;
            checks++;
            if ({wb_regWrite, wb_data, err_seen} !== {1'b1, exp, 1'b0}) begin
                failures++;
                $display("FAIL late_wb[k=%0d] got we=%b data=%h err=%b exp we=1 data=%h err=0",
                         k, wb_regWrite, wb_data, err_seen, exp);
            end
        end
    endtask

    task automatic test_timeout();
        int stalls, bubbles;
        logic err_early;
        logic [31:0] alu;
        clear_inputs();
        ex_memToReg = 1; ex_regWrite = 1; ex_rw = 5'd12; dm_rvalid = 0;
        stalls = 0; bubbles = 0; err_early = 0;
        for (int c = 0; c < int'(WaitLimit); c++) begin
            #1;
            if (mem_stall) stalls++;
            err_early |= mem_busErr;
            tick();
            if (wb_regWrite !== 1'b0) bubbles++;
        end
        #1;
        checks++;
        if ({stalls, bubbles, err_early, mem_stall, mem_busErr} !== {int'(WaitLimit), 32'd0, 3'b000}) begin
            failures++;
            $display("FAIL timeout_wait stalls=%0d bubbles_written=%0d err_early=%b stall_now=%b err_now=%b exp_stalls=%0d",
                     stalls, bubbles, err_early, mem_stall, mem_busErr, WaitLimit);
        end
        tick();
        checks++;
        if ({wb_regWrite, mem_busErr} !== 2'b01) begin
            failures++;
            $display("FAIL timeout_pulse got we=%b err=%b exp we=0 err=1", wb_regWrite, mem_busErr);
        end
        clear_inputs();
        alu = $urandom;
        ex_regWrite = 1; ex_rw = 5'd7; ex_exout = alu;
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle got stall=%b exp=0", mem_stall);
        end
        tick();
        checks++;
        if ({mem_busErr, wb_regWrite, wb_data} !== {1'b0, 1'b1, alu}) begin
            failures++;
            $display("FAIL timeout_after got=%h exp=%h", {mem_busErr, wb_regWrite, wb_data},
                     {1'b0, 1'b1, alu});
        end
    endtask

    task automatic test_branch();
        logic e_c;
        logic [29:0] e_pc;
        int pulses;
        logic first_ok;
        // Mispredicted branch, then predicted-taken (no correction).
        for (int i = 0; i < 2; i++) begin
            clear_inputs();
            ex_branchType = 3'd1; ex_commitAtMEM = 1; ex_predictAvail = (i == 1);
            ex_EXBranchAvail = 1; ex_BPC = 30'h100; ex_NOJPC = 30'h200;
            #1;
            checks++;
            if (i == 0 && {correctAtMEM, correctPCAtMEM} !== {1'b1, 30'h100}) begin
                failures++;
                $display("FAIL br_mispredict got=%b/%h exp=1/100", correctAtMEM, correctPCAtMEM);
            end else if (i == 1 && correctAtMEM !== 1'b0) begin
                failures++;
                $display("FAIL br_predicted got=%b exp=0", correctAtMEM);
            end
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            clear_inputs();
            ex_branchType = (i < 2) ? 3'd0 : 3'($urandom); ex_commitAtMEM = 1'($urandom) | (i < 2);
            ex_predictAvail = 1'($urandom); ex_EXBranchAvail = ~ex_predictAvail ^ 1'($urandom);
            ex_BPC = 30'($urandom); ex_NOJPC = 30'($urandom);
            e_c = ex_commitAtMEM && (ex_branchType != 3'd0) && (ex_predictAvail != ex_EXBranchAvail);
            e_pc = ex_EXBranchAvail ? ex_BPC : ex_NOJPC;
            #1;
            checks++;
            if (correctAtMEM !== e_c || (e_c && correctPCAtMEM !== e_pc)) begin
                failures++;
                $display("FAIL br_rand[%0d] got=%b/%h exp=%b/%h", i, correctAtMEM, correctPCAtMEM,
                         e_c, e_pc);
            end
            tick();
        end
        // Mispredicted branch held by a slow load: one pulse, in its first cycle.
        clear_inputs();
        ex_branchType = 3'd2; ex_commitAtMEM = 1; ex_predictAvail = 0; ex_EXBranchAvail = 1;
        ex_BPC = 30'h3C0; ex_memToReg = 1;
        pulses = 0; first_ok = 0;
        for (int c = 0; c < 4; c++) begin
            dm_rvalid = (c == 3);
            #1;
            if (correctAtMEM) pulses++;
            if (c == 0) first_ok = correctAtMEM;
            tick();
        end
        checks++;
        if (pulses !== 1 || first_ok !== 1'b1) begin
            failures++;
            $display("FAIL br_held pulses=%0d first=%b exp pulses=1 first=1", pulses, first_ok);
        end
        ex_memToReg = 0; dm_rvalid = 0;
        #1;
        checks++;
        if (correctAtMEM !== 1'b1) begin
            failures++;
            $display("FAIL br_next_instr got=%b exp=1", correctAtMEM);
        end
        tick();
    endtask

    // Abort a waiting load with mem_flush (use_rst=0) or rst (use_rst=1).
    task automatic test_abort_wait(input logic use_rst);
        logic [31:0] alu;
        clear_inputs();
        ex_memToReg = 1; ex_regWrite = 1; ex_rw = 5'd9; dm_rvalid = 0;
        tick(); tick();
        if (use_rst) rst = 1; else mem_flush = 1;
        tick();
        rst = 0; mem_flush = 0;
        checks++;
        if ({wb_regWrite, mem_busErr} !== 2'b00) begin
            failures++;
            $display("FAIL abort_wb[rst=%b] got we=%b err=%b exp 0/0", use_rst, wb_regWrite, mem_busErr);
        end
        clear_inputs();
        alu = $urandom;
        ex_regWrite = 1; ex_rw = 5'd3; ex_exout = alu;
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle[rst=%b] got stall=%b exp=0", use_rst, mem_stall);
        end
        tick();
        checks++;
        if ({wb_regWrite, wb_rw, wb_data} !== {1'b1, 5'd3, alu}) begin
            failures++;
            $display("FAIL abort_next[rst=%b] got=%h exp=%h", use_rst, {wb_regWrite, wb_rw, wb_data},
                     {1'b1, 5'd3, alu});
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_hit();
        test_back_to_back();
        test_timeout();
        test_branch();
        test_abort_wait(1'b0);
        test_abort_wait(1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
